// File: rtl/sfx_beep_arbiter.sv
// Beep output arbiter: passes background music, preempted by prioritised square-wave sound effects.
// Optional build macro SFX_DUCK_EN adds a post-effect music mute (DUCK state).
module sfx_beep_arbiter #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned HIT_HP   = 47774,
    parameter int unsigned MISS_HP  = 113636,
    parameter int unsigned OVER_HP  = 191131,
    parameter int unsigned HIT_MS   = 80,
    parameter int unsigned MISS_MS  = 200,
    parameter int unsigned OVER_MS  = 600,
    parameter int unsigned GAP_MS   = 20,
    parameter int unsigned DUCK_MS  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       music_en,
    input  logic       music_beep,
    input  logic [2:0] sfx_req,
    output logic       beep,
    output logic [1:0] sfx_cur,
    output logic       sfx_busy
);

`ifdef SFX_DUCK_EN
    typedef enum logic [1:0] {StIdle, StPlay, StGap, StDuck} state_e;
`else
    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;
`endif

    localparam logic [15:0] TICK_M1    = 16'(TICK_DIV - 1);
    localparam logic [17:0] HIT_HP_M1  = 18'(HIT_HP - 1);
    localparam logic [17:0] MISS_HP_M1 = 18'(MISS_HP - 1);
    localparam logic [17:0] OVER_HP_M1 = 18'(OVER_HP - 1);
    localparam logic [9:0]  HIT_MS_M1  = 10'(HIT_MS - 1);
    localparam logic [9:0]  MISS_MS_M1 = 10'(MISS_MS - 1);
    localparam logic [9:0]  OVER_MS_M1 = 10'(OVER_MS - 1);
    localparam logic [9:0]  GAP_MS_M1  = 10'(GAP_MS - 1);
`ifdef SFX_DUCK_EN
    localparam logic [9:0]  DUCK_MS_M1 = 10'(DUCK_MS - 1);
`endif

    state_e      state;
    logic        tone;
    logic [17:0] tone_cnt;
    logic [15:0] presc;
    logic [9:0]  dur;
    logic [1:0]  pending;

    logic [1:0]  req_id;
    logic [1:0]  pend_merge;
    logic [17:0] hp_m1;
    logic [9:0]  ms_m1;
    logic [9:0]  lim_m1;
    logic        tick;
    logic        period_done;
    logic        start;
    logic [1:0]  start_id;
    logic        music;

    // Request id doubles as priority: over(3) > miss(2) > hit(1).
    always_comb begin
        req_id = 2'd0;
        if (sfx_req[2]) begin
            req_id = 2'd3;
        end else if (sfx_req[1]) begin
            req_id = 2'd2;
        end else if (sfx_req[0]) begin
            req_id = 2'd1;
        end
    end

    assign pend_merge = (req_id > pending) ? req_id : pending;
    assign music      = music_beep & music_en;

    always_comb begin
        hp_m1 = HIT_HP_M1;
        ms_m1 = HIT_MS_M1;
        case (sfx_cur)
            2'd2: begin
                hp_m1 = MISS_HP_M1;
                ms_m1 = MISS_MS_M1;
            end
            2'd3: begin
                hp_m1 = OVER_HP_M1;
                ms_m1 = OVER_MS_M1;
            end
            default: begin
                hp_m1 = HIT_HP_M1;
                ms_m1 = HIT_MS_M1;
            end
        endcase
    end

    always_comb begin
        lim_m1 = ms_m1;
        case (state)
            StGap:   lim_m1 = GAP_MS_M1;
`ifdef SFX_DUCK_EN
            StDuck:  lim_m1 = DUCK_MS_M1;
`endif
            default: lim_m1 = ms_m1;
        endcase
    end

    assign tick        = (presc == TICK_M1);
    assign period_done = tick && (dur == lim_m1);

    // Decide whether this edge (re)starts an effect, and with which id.
    always_comb begin
        start    = 1'b0;
        start_id = req_id;
        case (state)
            StIdle: start = (req_id != 2'd0);
            StPlay: start = (req_id > sfx_cur);
            StGap: begin
                start    = period_done && (pend_merge != 2'd0);
                start_id = pend_merge;
            end
`ifdef SFX_DUCK_EN
            StDuck: start = (req_id != 2'd0);
`endif
            default: start = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            beep     <= 1'b0;
            sfx_cur  <= 2'd0;
            sfx_busy <= 1'b0;
            tone     <= 1'b0;
            tone_cnt <= '0;
            presc    <= '0;
            dur      <= '0;
            pending  <= 2'd0;
        end else if (start) begin
            state    <= StPlay;
            sfx_cur  <= start_id;
            tone     <= 1'b1;
            beep     <= 1'b1;
            sfx_busy <= 1'b1;
            tone_cnt <= '0;
            presc    <= '0;
            dur      <= '0;
            if (state == StGap) begin
                pending <= 2'd0;
            end
        end else begin
            case (state)
                StIdle: begin
                    beep     <= music;
                    sfx_busy <= 1'b0;
                end
                StPlay: begin
                    pending <= pend_merge;
                    if (period_done) begin
                        state    <= StGap;
                        beep     <= 1'b0;
                        sfx_cur  <= 2'd0;
                        tone     <= 1'b0;
                        tone_cnt <= '0;
                        presc    <= '0;
                        dur      <= '0;
                    end else begin
                        presc <= tick ? 16'd0 : presc + 16'd1;
                        dur   <= tick ? dur + 10'd1 : dur;
                        if (tone_cnt == hp_m1) begin
                            tone_cnt <= '0;
                            tone     <= ~tone;
                            beep     <= ~tone;
                        end else begin
                            tone_cnt <= tone_cnt + 18'd1;
                            beep     <= tone;
                        end
                    end
                end
                StGap: begin
                    beep <= 1'b0;
                    if (period_done) begin
                        presc <= '0;
                        dur   <= '0;
`ifdef SFX_DUCK_EN
                        state <= StDuck;
`else
                        state    <= StIdle;
                        beep     <= music;
                        sfx_busy <= 1'b0;
`endif
                    end else begin
                        pending <= pend_merge;
                        presc   <= tick ? 16'd0 : presc + 16'd1;
                        dur     <= tick ? dur + 10'd1 : dur;
                    end
                end
`ifdef SFX_DUCK_EN
                StDuck: begin
                    beep <= 1'b0;
                    if (period_done) begin
                        state    <= StIdle;
                        beep     <= music;
                        sfx_busy <= 1'b0;
                        presc    <= '0;
                        dur      <= '0;
                    end else begin
                        presc <= tick ? 16'd0 : presc + 16'd1;
                        dur   <= tick ? dur + 10'd1 : dur;
                    end
                end
`endif
                default: begin
                    state    <= StIdle;
                    beep     <= 1'b0;
                    sfx_cur  <= 2'd0;
                    sfx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
